// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the conv -> dense feature-map path: frame geometry,
// element type, derived index widths and the stream reader's state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package nn_pkg;

  localparam int FMAP_CHANNELS = 32;
  localparam int FMAP_HEIGHT   = 13;
  localparam int FMAP_WIDTH    = 13;
  localparam int FMAP_DATA_W   = 8;

  localparam int FMAP_ELEMS = FMAP_CHANNELS * FMAP_HEIGHT * FMAP_WIDTH;
  localparam int FMAP_BITS  = FMAP_ELEMS * FMAP_DATA_W;

  localparam int CHAN_W = $clog2(FMAP_CHANNELS);
  localparam int ROW_W  = $clog2(FMAP_HEIGHT);
  localparam int COL_W  = $clog2(FMAP_WIDTH);
  localparam int IDX_W  = $clog2(FMAP_ELEMS);
  localparam int BIT_W  = $clog2(FMAP_BITS);

  typedef logic signed [FMAP_DATA_W-1:0] fmap_elem_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    ACK,
    WAIT_LOW
  } fsr_state_t;

endpackage

// File: rtl/fmap_index_counter.sv
// -----------------------------------------------------------------------------
// fmap_index_counter
// Nested chan/row/col counters walking a feature-map frame in element order
// (col fastest, then row, then chan), plus the matching flat index.
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   clear            return all counters to 0 (priority over advance)
//   advance          step to the next element
//   chan/row/col     current element indices
//   idx              current flat element index
//   last_chan        current element is the last of its channel
//   last_frame       current element is the last of the frame
// The owner never advances past the last element, so counters stay in range.
// -----------------------------------------------------------------------------
module fmap_index_counter
  import nn_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [CHAN_W-1:0] chan,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [IDX_W-1:0]  idx,
  output logic              last_chan,
  output logic              last_frame
);

  localparam logic [CHAN_W-1:0] CHAN_MAX = CHAN_W'(FMAP_CHANNELS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(FMAP_HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(FMAP_WIDTH - 1);

  assign last_chan  = (row == ROW_MAX) && (col == COL_MAX);
  assign last_frame = last_chan && (chan == CHAN_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      chan <= '0;
      row  <= '0;
      col  <= '0;
      idx  <= '0;
    end else if (advance) begin
      idx <= idx + IDX_W'(1);
      if (col == COL_MAX) begin
        col <= '0;
        if (row == ROW_MAX) begin
          row  <= '0;
          chan <= chan + CHAN_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_stream_reader.sv
// -----------------------------------------------------------------------------
// fmap_stream_reader
// Streams a packed 13x13x32 feature map, read in place from the producer's
// bus, one element per valid/ready beat, then acknowledges the frame.
// Ports:
//   clock, reset_n      rising-edge clock, synchronous active-low reset
//   feat_valid          producer done level; feat_img complete and stable
//   feat_img            packed frame, element d at [d*8 +: 8]
//   feat_ack            one-cycle pulse after the last beat transfers
//   m_valid / m_ready   stream handshake
//   m_data              element value (signed, registered)
//   m_chan/m_row/m_col  indices of the current beat
//   m_last_chan         beat ends a channel
//   m_last_frame        beat ends the frame
//   busy                reader is not idle
//   chksum              running frame checksum
// Optional feature macro: FSR_CHKSUM_EN. When defined, chksum accumulates the
// sign-extended beats of the frame modulo 2^16; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module fmap_stream_reader
  import nn_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 feat_valid,
  input  logic [FMAP_BITS-1:0] feat_img,
  output logic                 feat_ack,
  output logic                 m_valid,
  input  logic                 m_ready,
  output fmap_elem_t           m_data,
  output logic [CHAN_W-1:0]    m_chan,
  output logic [ROW_W-1:0]     m_row,
  output logic [COL_W-1:0]     m_col,
  output logic                 m_last_chan,
  output logic                 m_last_frame,
  output logic                 busy,
  output logic [15:0]          chksum
);

  fsr_state_t       state, state_next;
  logic             xfer;
  logic             load_first;
  logic             cnt_clear;
  logic             cnt_advance;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] load_idx;
  logic [BIT_W-1:0] elem_lsb;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (feat_valid) state_next = STREAM;
      STREAM:   if (xfer && m_last_frame) state_next = ACK;
      ACK:      state_next = WAIT_LOW;
      WAIT_LOW: if (!feat_valid) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign m_valid  = (state == STREAM);
  assign feat_ack = (state == ACK);
  assign busy     = (state != IDLE);
  assign xfer     = m_valid && m_ready;

  // The counter tracks the beat currently on the output; it sits at zero
  // outside STREAM so the index outputs idle at 0.
  assign load_first  = (state == IDLE) && feat_valid;
  assign cnt_clear   = (state != STREAM) || (xfer && m_last_frame);
  assign cnt_advance = xfer && !m_last_frame;

  fmap_index_counter u_index (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .chan       (m_chan),
    .row        (m_row),
    .col        (m_col),
    .idx        (idx),
    .last_chan  (m_last_chan),
    .last_frame (m_last_frame)
  );

  // Element to present after this edge: 0 when a frame starts, else d+1.
  assign load_idx = load_first ? '0 : idx + IDX_W'(1);
  assign elem_lsb = BIT_W'(load_idx) * BIT_W'(FMAP_DATA_W);

  // m_data is the only register on the data path: the wide mux from feat_img
  // lands here, keeping feat_img off any combinational output path.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      m_data <= '0;
    end else if (load_first || cnt_advance) begin
      m_data <= feat_img[elem_lsb +: FMAP_DATA_W];
    end else if (xfer) begin
      m_data <= '0;
    end
  end

`ifdef FSR_CHKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clock) begin
    if (!reset_n || load_first) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + {{(16 - FMAP_DATA_W){m_data[FMAP_DATA_W-1]}}, m_data};
    end
  end

  assign chksum = sum_q;
`else
  assign chksum = 16'h0000;
`endif

endmodule
